// File: rtl/simon_responder.sv
// Player-side echo for the simon colour interface: records a presented colour
// sequence, waits a fixed gap, then replays it verbatim on the output.
module simon_responder #(
    parameter int DEPTH = 16,
    parameter int GAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] in,
    input  logic       in_valid,
    input  logic       in_last,
    output logic [1:0] out,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy,
    output logic       err,
    output logic [1:0] dbg_state
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_GAP    = 2'd2,
        S_REPLAY = 2'd3
    } state_t;

    state_t          state_q;
    logic [1:0]      mem_q [DEPTH];
    logic [LW-1:0]   len_q;
    logic [IW-1:0]   idx_q;
    logic [GW-1:0]   gcnt_q;
    logic [1:0]      out_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            busy_q;
    logic            err_q;

    // Symbol storage is not reset: it is only read back after a fresh capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            gcnt_q      <= '0;
            out_q       <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mem_q[0] <= in;
                        len_q    <= LW'(1);
                        busy_q   <= 1'b1;
                        gcnt_q   <= '0;
                        state_q  <= in_last ? S_GAP : S_RECORD;
                    end
                end
                S_RECORD: begin
                    if (in_valid) begin
                        mem_q[len_q[IW-1:0]] <= in;
                        len_q <= len_q + LW'(1);
                        // A full buffer ends capture just like an explicit last symbol.
                        if (in_last || len_q == LW'(DEPTH - 1)) begin
                            state_q <= S_GAP;
                            gcnt_q  <= '0;
                        end
                    end
                end
                S_GAP: begin
                    err_q <= in_valid;
                    if (gcnt_q == GW'(GAP)) begin
                        state_q     <= S_REPLAY;
                        out_valid_q <= 1'b1;
                        out_q       <= mem_q[0];
                        out_last_q  <= (len_q == LW'(1));
                        idx_q       <= IW'(1);
                    end else begin
                        gcnt_q <= gcnt_q + GW'(1);
                    end
                end
                S_REPLAY: begin
                    err_q <= in_valid;
                    if (out_last_q) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        out_q       <= 2'b00;
                        busy_q      <= 1'b0;
                        len_q       <= '0;
                    end else begin
                        out_q      <= mem_q[idx_q];
                        out_last_q <= (LW'(idx_q) == len_q - LW'(1));
                        idx_q      <= idx_q + IW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_simon_responder.sv
// Directed bench for simon_responder (DEPTH=16, GAP=2): capture, gap timing,
// replay content, overflow, collision error pulses and reset recovery.
module tb_simon_responder;

    logic       clock;
    logic       reset;
    logic [1:0] in;
    logic       in_valid;
    logic       in_last;
    logic [1:0] out;
    logic       out_valid;
    logic       out_last;
    logic       busy;
    logic       err;
    logic [1:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    simon_responder #(.DEPTH(16), .GAP(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // exp = {out_valid, out_last, out[1:0], busy, err}
    task automatic chk(input string tag, input logic [5:0] exp);
        total_cnt++;
        assert ({out_valid, out_last, out, busy, err} === exp) pass_cnt++;
        else $error("FAIL %s: got {ov,ol,out,busy,err}=%b want %b", tag,
                    {out_valid, out_last, out, busy, err}, exp);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        total_cnt++;
        assert (dbg_state === exp) pass_cnt++;
        else $error("FAIL %s: got state=%0d want %0d", tag, dbg_state, exp);
    endtask

    task automatic send(input logic [1:0] sym, input logic last);
        in       = sym;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in       = 2'b00;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the edge accepting the final symbol: three quiet
    // busy cycles, then lands on the first replay cycle.
    task automatic gap_chk(input string tag);
        repeat (3) begin
            chk(tag, 6'b0_0_00_1_0);
            tick();
        end
    endtask

    task automatic rep_chk(input string tag, input logic [1:0] sym, input logic last);
        chk(tag, {1'b1, last, sym, 1'b1, 1'b0});
        tick();
    endtask

    initial begin
        // Reset held with a symbol presented: nothing may be captured.
        reset    = 1'b1;
        in       = 2'b11;
        in_valid = 1'b1;
        in_last  = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 6'b0_0_00_0_0);
        chk_state("reset_state", 2'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        in       = 2'b00;
        tick();
        chk("post_reset_idle", 6'b0_0_00_0_0);

        // Basic echo 01,10,11.
        send(2'b01, 1'b0);
        chk("echo_busy", 6'b0_0_00_1_0);
        chk_state("echo_record", 2'd1);
        send(2'b10, 1'b0);
        send(2'b11, 1'b1);
        chk_state("echo_gap_state", 2'd2);
        gap_chk("echo_gap");
        chk_state("echo_replay_state", 2'd3);
        rep_chk("echo_r0", 2'b01, 1'b0);
        rep_chk("echo_r1", 2'b10, 1'b0);
        rep_chk("echo_r2", 2'b11, 1'b1);
        chk("echo_done", 6'b0_0_00_0_0);
        chk_state("echo_idle", 2'd0);

        // Holes in capture, then a single-symbol sequence.
        send(2'b00, 1'b0);
        tick();
        tick();
        chk("holes_wait", 6'b0_0_00_1_0);
        send(2'b10, 1'b1);
        gap_chk("holes_gap");
        rep_chk("holes_r0", 2'b00, 1'b0);
        rep_chk("holes_r1", 2'b10, 1'b1);
        chk("holes_done", 6'b0_0_00_0_0);
        send(2'b11, 1'b1);
        gap_chk("single_gap");
        rep_chk("single_r0", 2'b11, 1'b1);
        chk("single_done", 6'b0_0_00_0_0);

        // Overflow: 16 symbols fill the buffer, the 17th is dropped in GAP.
        for (int i = 0; i < 16; i++) send(2'(i % 4), 1'b0);
        chk_state("ovf_forced_gap", 2'd2);
        chk("ovf_gap0", 6'b0_0_00_1_0);
        send(2'b00, 1'b0);
        chk("ovf_err", 6'b0_0_00_1_1);
        tick();
        chk("ovf_gap2", 6'b0_0_00_1_0);
        tick();
        for (int i = 0; i < 16; i++) rep_chk("ovf_rep", 2'(i % 4), (i == 15));
        chk("ovf_done", 6'b0_0_00_0_0);

        // Collisions during GAP and on the out_last cycle.
        send(2'b10, 1'b0);
        send(2'b01, 1'b1);
        chk("col_gap0", 6'b0_0_00_1_0);
        in       = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("col_gap_err", 6'b0_0_00_1_1);
        tick();
        chk("col_gap2", 6'b0_0_00_1_0);
        tick();
        rep_chk("col_r0", 2'b10, 1'b0);
        chk("col_r1", 6'b1_1_01_1_0);
        in       = 2'b11;
        in_valid = 1'b1;
        tick();
        chk("col_last_err", 6'b0_0_00_0_1);
        chk_state("col_idle", 2'd0);
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in       = 2'b00;
        gap_chk("col_new_gap");
        rep_chk("col_new_r0", 2'b11, 1'b1);
        chk("col_new_done", 6'b0_0_00_0_0);

        // Reset on the second replay cycle, then recovery.
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b11, 1'b1);
        gap_chk("mrst_gap");
        rep_chk("mrst_r0", 2'b01, 1'b0);
        chk("mrst_r1", 6'b1_0_10_1_0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_cleared", 6'b0_0_00_0_0);
        chk_state("mrst_idle", 2'd0);
        tick();
        chk("mrst_quiet", 6'b0_0_00_0_0);
        send(2'b10, 1'b0);
        send(2'b00, 1'b1);
        gap_chk("mrst_new_gap");
        rep_chk("mrst_new_r0", 2'b10, 1'b0);
        rep_chk("mrst_new_r1", 2'b00, 1'b1);
        chk("mrst_new_done", 6'b0_0_00_0_0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
